updown_sat_counter: RTL and testbench
=====================================

Name: updown_sat_counter

Overview:
- Parametrised up/down counter; successor to the fixed 3-bit, up-only, saturating counter.
- Adds configurable width and ceiling, decrement, synchronous clear and parallel load, saturate-or-wrap mode, boundary flags, and overflow/underflow pulses.
- Used for score, lives and level tracking in the Frogger datapath; drives the display decoders.

Parameters:
- WIDTH, 3: counter width in bits.
- MAX_VAL, 7: upper count bound. Must be less than 2**WIDTH.
- WRAP, 0: 0 = saturate at the bounds; 1 = wrap MAX_VAL->0 and 0->MAX_VAL.
- RESET_VAL, 0: value of out after reset or clear. Must be no greater than MAX_VAL.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- clear  input  1  synchronous clear to RESET_VAL.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value taken when load is asserted.
- up  input  1  increment request.
- down  input  1  decrement request.
- out  output  WIDTH  current count (registered).
- at_max  output  1  high while out == MAX_VAL.
- at_min  output  1  high while out == 0.
- overflow  output  1  one-cycle pulse on increment at MAX_VAL.
- underflow  output  1  one-cycle pulse on decrement at 0.

Behaviour:
- Reset (reset=0, asynchronous, immediate):
  - out=RESET_VAL, overflow=0, underflow=0; edge-detect history regs =0.
  - at_max/at_min follow out.
  - Release is synchronous to clk; first update on the first rising edge with reset=1.
- Priority per cycle: clear > load > up/down.
  - clear=1: next out=RESET_VAL; no pulses.
  - load=1: next out=load_val, clamped to MAX_VAL if load_val>MAX_VAL; no pulses.
  - Effective up=1 and down=0:
    - out<MAX_VAL: out+1.
    - out==MAX_VAL: next out = MAX_VAL (WRAP=0) or 0 (WRAP=1); overflow=1 next cycle.
  - Effective down=1 and up=0:
    - out>0: out-1.
    - out==0: next out = 0 (WRAP=0) or MAX_VAL (WRAP=1); underflow=1 next cycle.
  - up=1 and down=1: hold; no pulses.
  - Neither asserted: hold.
- Latency:
  - One clock from request to updated out.
  - overflow/underflow are registered and assert in the same cycle out shows the result; they last exactly one cycle unless the event repeats.
- at_max and at_min are combinational decodes of the out register; no extra latency.
- Arithmetic: unsigned, WIDTH bits. No intermediate value beyond MAX_VAL is ever visible on out.
- clear or load asserted in the same cycle as a boundary up/down suppresses the pulse.

Optional Feature:
- Macro: UPDOWN_COUNTER_EDGE_DETECT_EN.
- Defined:
  - up and down are rising-edge qualified: effective up = up & ~up_q, where up_q is up registered on clk; same for down.
  - Holding up for N cycles gives a single increment.
  - History regs update every cycle, including during clear and load.
  - History regs reset to 0, so an input already high at reset release counts once.
- Undefined:
  - Level-sensitive: one step per cycle while the input is held.
  - No history registers are synthesised.

Test Plan:
- Defaults, level mode: reset=0 then 1; up=1 for 10 cycles -> out 0,1..7 then holds 7; at_max=1 from the cycle out=7; overflow=1 on each cycle up is held at 7.
- WRAP=1, MAX_VAL=5, WIDTH=3: up held from 0 -> 1,2,3,4,5,0,1; overflow=1 only in the cycle out shows 0. Then down from 0 -> 5 with a one-cycle underflow.
- Priority: out=4; clear=1, load=1, up=1 same cycle -> out=0. Next: load=1, load_val=3, down=1 -> out=3, no pulses. Next: load_val=7 with MAX_VAL=6 -> out=6.
- Simultaneous: out=2; up=1, down=1 for 3 cycles -> out stays 2, overflow=underflow=0. Then down alone from 0 with WRAP=0 -> out 0, underflow pulses.
- Async reset mid-count: out=5; drop reset between clock edges -> out=RESET_VAL immediately with no clock edge; pulses cleared. Repeat with RESET_VAL=3 -> out=3.
- Macro defined: up held 6 cycles -> out 0->1 only. Toggling up 1/0 four times -> out=4. Up high across reset release -> single increment to 1.

Source files
------------

// File: rtl/updown_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : updown_sat_counter
// Purpose  : Parametrised up/down counter with saturate-or-wrap bounds,
//            clear/load, boundary flags and overflow/underflow pulses.
//            Optional rising-edge qualification of up/down via
//            UPDOWN_COUNTER_EDGE_DETECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module updown_sat_counter #(
  parameter int WIDTH     = 3,
  parameter int MAX_VAL   = 7,
  parameter int WRAP      = 0,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  input  logic             down,
  output logic [WIDTH-1:0] out,
  output logic             at_max,
  output logic             at_min,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [WIDTH-1:0] C_MAX  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] C_RST  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_ZERO = '0;

  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             w_up, w_dn;

`ifdef UPDOWN_COUNTER_EDGE_DETECT_EN
  logic up_q, down_q;

  // History resets to 0 so an input already high at release counts once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
    end else begin
      up_q   <= up;
      down_q <= down;
    end
  end

  assign w_up = up & ~up_q;
  assign w_dn = down & ~down_q;
`else
  assign w_up = up;
  assign w_dn = down;
`endif

  always_comb begin
    out_d = out_q;
    ovf_d = 1'b0;
    udf_d = 1'b0;
    if (clear) begin
      out_d = C_RST;
    end else if (load) begin
      out_d = (load_val > C_MAX) ? C_MAX : load_val;
    end else if (w_up && !w_dn) begin
      if (out_q >= C_MAX) begin
        ovf_d = 1'b1;
        out_d = (WRAP != 0) ? C_ZERO : C_MAX;
      end else begin
        out_d = out_q + C_ONE;
      end
    end else if (w_dn && !w_up) begin
      if (out_q == C_ZERO) begin
        udf_d = 1'b1;
        out_d = (WRAP != 0) ? C_MAX : C_ZERO;
      end else begin
        out_d = out_q - C_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= C_RST;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign out       = out_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;
  assign at_max    = (out_q == C_MAX);
  assign at_min    = (out_q == C_ZERO);

endmodule
`default_nettype wire

// File: tb/tb_updown_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_updown_sat_counter
// Purpose  : Directed self-checking bench for updown_sat_counter across three
//            parameter sets (default, wrap MAX=5, MAX=6 with RESET_VAL=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_updown_sat_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [3];
  logic       clr   [3];
  logic       ld    [3];
  logic [2:0] lv    [3];
  logic       upi   [3];
  logic       dni   [3];
  logic [2:0] cnt   [3];
  logic       amax  [3];
  logic       amin  [3];
  logic       ovf   [3];
  logic       udf   [3];

  int n_vec = 0;
  int n_err = 0;
  int exp2 [7] = '{1, 2, 3, 4, 5, 0, 1};

  updown_sat_counter u0 (
    .clk(clk), .reset(rst_n[0]), .clear(clr[0]), .load(ld[0]), .load_val(lv[0]),
    .up(upi[0]), .down(dni[0]), .out(cnt[0]), .at_max(amax[0]), .at_min(amin[0]),
    .overflow(ovf[0]), .underflow(udf[0])
  );

  updown_sat_counter #(.WIDTH(3), .MAX_VAL(5), .WRAP(1), .RESET_VAL(0)) u1 (
    .clk(clk), .reset(rst_n[1]), .clear(clr[1]), .load(ld[1]), .load_val(lv[1]),
    .up(upi[1]), .down(dni[1]), .out(cnt[1]), .at_max(amax[1]), .at_min(amin[1]),
    .overflow(ovf[1]), .underflow(udf[1])
  );

  updown_sat_counter #(.WIDTH(3), .MAX_VAL(6), .WRAP(0), .RESET_VAL(3)) u2 (
    .clk(clk), .reset(rst_n[2]), .clear(clr[2]), .load(ld[2]), .load_val(lv[2]),
    .up(upi[2]), .down(dni[2]), .out(cnt[2]), .at_max(amax[2]), .at_min(amin[2]),
    .overflow(ovf[2]), .underflow(udf[2])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; clr[i] = 1'b0; ld[i] = 1'b0;
      lv[i] = 3'd0; upi[i] = 1'b0; dni[i] = 1'b0;
    end
    #12;
    chk("rst_u0_out",  cnt[0], 0);
    chk("rst_u0_amin", amin[0], 1);
    chk("rst_u0_amax", amax[0], 0);
    chk("rst_u0_ovf",  ovf[0], 0);
    chk("rst_u1_out",  cnt[1], 0);
    chk("rst_u2_out",  cnt[2], 3);
    chk("rst_u2_amin", amin[2], 0);
    step();
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

`ifndef UPDOWN_COUNTER_EDGE_DETECT_EN
    // Saturating count-up on the default instance
    upi[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("sat_out",  cnt[0], (k > 7) ? 7 : k);
      chk("sat_ovf",  ovf[0], (k >= 8) ? 1 : 0);
      chk("sat_amax", amax[0], (k >= 7) ? 1 : 0);
    end
    upi[0] = 1'b0;
    step();
    chk("sat_hold_out", cnt[0], 7);
    chk("sat_hold_ovf", ovf[0], 0);

    // Wrap instance: count through MAX_VAL=5 and back under zero
    upi[1] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("wrap_out", cnt[1], exp2[k-1]);
      chk("wrap_ovf", ovf[1], (k == 6) ? 1 : 0);
    end
    upi[1] = 1'b0; dni[1] = 1'b1;
    step();
    chk("wrap_dn_out", cnt[1], 0);
    chk("wrap_dn_udf", udf[1], 0);
    step();
    chk("wrap_under_out", cnt[1], 5);
    chk("wrap_under_udf", udf[1], 1);
    dni[1] = 1'b0;
    step();
    chk("wrap_idle_out",  cnt[1], 5);
    chk("wrap_idle_udf",  udf[1], 0);
    chk("wrap_idle_amax", amax[1], 1);

    // Priority clear > load > up/down
    ld[0] = 1'b1; lv[0] = 3'd4;
    step();
    chk("pri_load4", cnt[0], 4);
    clr[0] = 1'b1; ld[0] = 1'b1; upi[0] = 1'b1;
    step();
    chk("pri_clr_out",  cnt[0], 0);
    chk("pri_clr_ovf",  ovf[0], 0);
    chk("pri_clr_amin", amin[0], 1);
    clr[0] = 1'b0; lv[0] = 3'd3; upi[0] = 1'b0; dni[0] = 1'b1;
    step();
    chk("pri_ld_out", cnt[0], 3);
    chk("pri_ld_udf", udf[0], 0);
    chk("pri_ld_ovf", ovf[0], 0);
    ld[0] = 1'b0; dni[0] = 1'b0;
    ld[2] = 1'b1; lv[2] = 3'd7;
    step();
    chk("clamp_out",  cnt[2], 6);
    chk("clamp_amax", amax[2], 1);
    ld[2] = 1'b0;

    // Simultaneous up/down holds
    ld[0] = 1'b1; lv[0] = 3'd2;
    step();
    ld[0] = 1'b0; upi[0] = 1'b1; dni[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("both_out", cnt[0], 2);
      chk("both_ovf", ovf[0], 0);
      chk("both_udf", udf[0], 0);
    end
    upi[0] = 1'b0; dni[0] = 1'b0; clr[0] = 1'b1;
    step();
    chk("clr0_out", cnt[0], 0);
    clr[0] = 1'b0; dni[0] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("sat_dn_out", cnt[0], 0);
      chk("sat_dn_udf", udf[0], 1);
    end
    dni[0] = 1'b0;
    step();
    chk("sat_dn_end_udf", udf[0], 0);

    // Asynchronous reset between clock edges
    ld[0] = 1'b1; lv[0] = 3'd7;
    step();
    ld[0] = 1'b0; upi[0] = 1'b1;
    step();
    chk("ar_pre_out", cnt[0], 7);
    chk("ar_pre_ovf", ovf[0], 1);
    #2 rst_n[0] = 1'b0;
    #1;
    chk("ar_out",  cnt[0], 0);
    chk("ar_ovf",  ovf[0], 0);
    chk("ar_amin", amin[0], 1);
    upi[0] = 1'b0;
    ld[2] = 1'b1; lv[2] = 3'd5;
    step();
    ld[2] = 1'b0;
    chk("ar2_pre", cnt[2], 5);
    #2 rst_n[2] = 1'b0;
    #1;
    chk("ar2_out", cnt[2], 3);
    step();
    rst_n[0] = 1'b1; rst_n[2] = 1'b1;
    step();
    chk("ar_rel_out", cnt[0], 0);
`else
    // Edge-qualified mode: a held request counts once
    upi[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("edge_hold_out", cnt[0], 1);
      chk("edge_hold_ovf", ovf[0], 0);
    end
    upi[0] = 1'b0;
    step();
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    chk("edge_clr", cnt[0], 0);
    for (int k = 1; k <= 4; k++) begin
      upi[0] = 1'b1;
      step();
      upi[0] = 1'b0;
      step();
      chk("edge_toggle", cnt[0], k);
    end
    rst_n[0] = 1'b0; upi[0] = 1'b1;
    step();
    chk("edge_rst_out", cnt[0], 0);
    rst_n[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("edge_rel_out", cnt[0], 1);
    end
    upi[0] = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
